nes_pad_emulator: RTL and testbench

Emulates a serial NES controller (CD4021-style parallel-in/serial-out) from the parallel MiSTer joystick word delivered by hps_io. display_top drives latch and nes_clk exactly as it would a physical pad, and this block returns the serial data bit. It sits directly upstream of display_top's data input and replaces the direct joystick-to-data connection. It adds SOCD cleaning and optional A/B turbo.

---
 rtl/nes_pad_emulator.sv | 91 +++++++++
 tb/tb_nes_pad_emulator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_emulator.sv
// rtl/nes_pad_emulator.sv - CD4021-style serial NES pad emulated from a parallel joystick word
// Adds SOCD cleaning and A/B turbo; loads transparently while latch is high.
module nes_pad_emulator #(
  parameter logic [23:0] TURBO_DIV = 24'd833_333,
  parameter logic        FILL_BIT  = 1'b1
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic [7:0] joystick,
  input  logic [1:0] turbo_en,
  input  logic       latch,
  input  logic       nes_clk,
  output logic       data,
  output logic       latch_fall
);

  logic [7:0]  r_sr;
  logic        r_latch_q;
  logic        r_nes_clk_q;
  logic        r_data;
  logic        r_latch_fall;
  logic [23:0] r_turbo_cnt;
  logic        r_phase;

  logic        w_rise;
  logic        w_fall;
  logic        w_u;
  logic        w_d;
  logic        w_l;
  logic        w_r;
  logic        w_a;
  logic        w_b;
  logic [7:0]  w_snap;
  logic [7:0]  w_sr_next;

  assign w_rise = nes_clk & ~r_nes_clk_q;
  assign w_fall = ~latch & r_latch_q;

  // Opposing directions pressed together cancel out
  assign w_u = joystick[3] & ~joystick[2];
  assign w_d = joystick[2] & ~joystick[3];
  assign w_l = joystick[1] & ~joystick[0];
  assign w_r = joystick[0] & ~joystick[1];

  assign w_a = joystick[4] & ~(turbo_en[0] & r_phase);
  assign w_b = joystick[5] & ~(turbo_en[1] & r_phase);

  assign w_snap = ~{w_r, w_l, w_d, w_u, joystick[7], joystick[6], w_b, w_a};

  always_comb begin
    w_sr_next = r_sr;
    if (latch) begin
      w_sr_next = w_snap;
    end else if (w_rise) begin
      w_sr_next = {FILL_BIT, r_sr[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      r_turbo_cnt <= 24'd0;
      r_phase     <= 1'b0;
    end else if (r_turbo_cnt == TURBO_DIV - 24'd1) begin
      r_turbo_cnt <= 24'd0;
      r_phase     <= ~r_phase;
    end else begin
      r_turbo_cnt <= r_turbo_cnt + 24'd1;
    end
  end

  // data follows sr one cycle later, giving two cycles from an input edge
  always_ff @(posedge clk) begin
    if (hard_reset) begin
      r_sr         <= 8'hFF;
      r_data       <= 1'b1;
      r_latch_fall <= 1'b0;
      r_latch_q    <= 1'b0;
      r_nes_clk_q  <= 1'b0;
    end else begin
      r_sr         <= w_sr_next;
      r_data       <= r_sr[0];
      r_latch_fall <= w_fall;
      r_latch_q    <= latch;
      r_nes_clk_q  <= nes_clk;
    end
  end

  assign data       = r_data;
  assign latch_fall = r_latch_fall;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// tb/tb_nes_pad_emulator.sv - scoreboard bench for nes_pad_emulator
module tb_nes_pad_emulator;

  localparam int TDIV = 4;

  logic       clk;
  logic       hard_reset;
  logic [7:0] joystick;
  logic [1:0] turbo_en;
  logic       latch;
  logic       nes_clk;
  logic       data;
  logic       latch_fall;

  int checks;
  int failures;
  logic exp_q[$];

  int   m_cnt;
  logic m_phase;

  nes_pad_emulator #(.TURBO_DIV(24'd4), .FILL_BIT(1'b1)) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .joystick   (joystick),
    .turbo_en   (turbo_en),
    .latch      (latch),
    .nes_clk    (nes_clk),
    .data       (data),
    .latch_fall (latch_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference turbo phase: counts 0..TDIV-1, toggles on wrap
  always @(posedge clk) begin
    if (hard_reset) begin
      m_cnt   <= 0;
      m_phase <= 1'b0;
    end else if (m_cnt == TDIV - 1) begin
      m_cnt   <= 0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [7:0] model_snap(input logic [7:0] joy, input logic [1:0] ten,
                                            input logic ph);
    logic r, l, d, u, a, b;
    r = joy[0]; l = joy[1]; d = joy[2]; u = joy[3];
    if (u && d) begin u = 1'b0; d = 1'b0; end
    if (l && r) begin l = 1'b0; r = 1'b0; end
    a = joy[4] & ~(ten[0] & ph);
    b = joy[5] & ~(ten[1] & ph);
    return ~{r, l, d, u, joy[7], joy[6], b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_latch(input logic [7:0] joy, input logic [1:0] ten, input string name);
    logic       ph;
    logic [7:0] snap;
    joystick = joy;
    turbo_en = ten;
    latch    = 1'b1;
    ph       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ph = m_phase;
      tick();
    end
    latch = 1'b0;
    snap  = model_snap(joy, ten, ph);
    for (int i = 0; i < 8; i++) exp_q.push_back(snap[i]);
    tick();
    checks++;
    if (latch_fall !== 1'b1) begin
      failures++;
      $display("FAIL %s latch_fall_pulse: got %b want 1", name, latch_fall);
    end
    tick();
    checks++;
    if (latch_fall !== 1'b0) begin
      failures++;
      $display("FAIL %s latch_fall_single: got %b want 0", name, latch_fall);
    end
    tick();
  endtask

  task automatic run_pulses(input int n, input string name);
    logic e;
    for (int p = 0; p < n; p++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s scoreboard_empty: got none want bit %0d", name, p);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          failures++;
          $display("FAIL %s bit%0d: got %b want %b", name, p, data, e);
        end
      end
      nes_clk = 1'b1;
      repeat (4) tick();
      nes_clk = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic test_reset();
    joystick   = 8'hFF;
    hard_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) hard_reset = 1'b0;
      checks++;
      if (data !== 1'b1 || latch_fall !== 1'b0 || dut.r_sr !== 8'hFF) begin
        failures++;
        $display("FAIL reset cyc%0d: got data=%b latch_fall=%b sr=%h want 1 0 ff",
                 i, data, latch_fall, dut.r_sr);
      end
    end
  endtask

  task automatic test_basic_read();
    do_latch(8'b1001_0001, 2'b00, "basic");
    run_pulses(8, "basic");
    checks++;
    if (data !== 1'b1) begin
      failures++;
      $display("FAIL basic after8: got %b want 1", data);
    end
  endtask

  task automatic test_extra_reads();
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    run_pulses(4, "extra");
    checks++;
    if (data !== 1'b1) begin
      failures++;
      $display("FAIL extra after12: got %b want 1", data);
    end
  endtask

  task automatic test_socd();
    do_latch(8'b0000_1111, 2'b00, "socd");
    run_pulses(8, "socd");
  endtask

  task automatic test_turbo();
    logic e;
    joystick = 8'h30;
    turbo_en = 2'b01;
    latch    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back(~(joystick[4] & ~(turbo_en[0] & m_phase)));
      tick();
      if (i >= 1) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
          failures++;
          $display("FAIL turbo_live cyc%0d: got %b want %b", i, data, e);
        end
      end
    end
    exp_q.delete();
    latch = 1'b0;
    repeat (3) tick();
    do_latch(8'h30, 2'b01, "turbo_a");
    run_pulses(8, "turbo_a");
    do_latch(8'h30, 2'b01, "turbo_b");
    run_pulses(8, "turbo_b");
    turbo_en = 2'b00;
  endtask

  task automatic test_priority();
    logic [7:0] snap;
    joystick = 8'h10;
    turbo_en = 2'b00;
    latch    = 1'b1;
    repeat (3) tick();
    nes_clk = 1'b1;
    tick();
    latch = 1'b0;
    snap  = model_snap(8'h10, 2'b00, 1'b0);
    repeat (3) tick();
    checks++;
    if (data !== snap[0]) begin
      failures++;
      $display("FAIL priority data: got %b want %b", data, snap[0]);
    end
    nes_clk = 1'b0;
    repeat (4) tick();
    for (int i = 1; i < 8; i++) exp_q.push_back(snap[i]);
    nes_clk = 1'b1;
    repeat (4) tick();
    nes_clk = 1'b0;
    repeat (4) tick();
    run_pulses(7, "priority");
  endtask

  task automatic test_midop_reset();
    do_latch(8'h20, 2'b00, "midop");
    run_pulses(3, "midop");
    exp_q.delete();
    hard_reset = 1'b1;
    tick();
    checks++;
    if (data !== 1'b1) begin
      failures++;
      $display("FAIL midop reset_data: got %b want 1", data);
    end
    hard_reset = 1'b0;
    tick();
    do_latch(8'h41, 2'b00, "reload");
    run_pulses(8, "reload");
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    hard_reset = 1'b1;
    joystick   = 8'h00;
    turbo_en   = 2'b00;
    latch      = 1'b0;
    nes_clk    = 1'b0;
    test_reset();
    test_basic_read();
    test_extra_reads();
    test_socd();
    test_turbo();
    test_priority();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
